// File: rtl/binario_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// The FSM state encoding and a digit-count sizing helper live here.
package binario_bcd_seq_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  // ceil(largura * log10(2)) in integer fixed point (log10(2) ~ 0.30103)
  function automatic int digitos_min(input int largura);
    return (largura * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/binario_bcd_seq_if.sv
// Start/ready handshake and result bus of the binary-to-BCD converter.
// The master drives the request; the slave (the converter) returns the result.
interface binario_bcd_seq_if #(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 10
);
  logic                   inicio;
  logic [LARGURA-1:0]     binario;
  logic                   com_sinal;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   bcd;
  logic                   negativo;
  logic                   estouro;

  modport master (
    output inicio, binario, com_sinal,
    input  ocupado, pronto, bcd, negativo, estouro
  );

  modport slave (
    input  inicio, binario, com_sinal,
    output ocupado, pronto, bcd, negativo, estouro
  );
endinterface

// File: rtl/binario_bcd_seq_ajuste.sv
// Per-digit add-3 correction used by the shift-and-add-3 step.
module bcd_ajuste (
  input  logic [3:0] entrada,
  output logic [3:0] saida
);
  assign saida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;
endmodule

// File: rtl/binario_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// with sign/magnitude handling, overflow flag and start/ready handshake.
module binario_bcd_seq
  import binario_bcd_seq_pkg::*;
#(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 10
) (
  input logic              clock,
  input logic              reset,
  binario_bcd_seq_if.slave bus
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t              estado, proximo;
  logic                 carga, passo;
  logic [CW-1:0]        contador;
  logic [LARGURA-1:0]   magnitude;
  logic [4*DIGITOS-1:0] digitos, ajustados, digitos_prox;
  logic                 ovf_int, ovf_prox, neg_int;
  logic [4*DIGITOS-1:0] bcd_q;
  logic                 neg_q, est_q;
  logic                 neg_entrada;
  logic [LARGURA-1:0]   mag_entrada;

  for (genvar k = 0; k < DIGITOS; k++) begin : g_ajuste
    bcd_ajuste u_ajuste (
      .entrada (digitos[4*k +: 4]),
      .saida   (ajustados[4*k +: 4])
    );
  end

  // The bit leaving the top digit means the value needs more than DIGITOS digits.
  assign digitos_prox = {ajustados[4*DIGITOS-2:0], magnitude[LARGURA-1]};
  assign ovf_prox     = ovf_int | ajustados[4*DIGITOS-1];

  assign neg_entrada  = bus.com_sinal & bus.binario[LARGURA-1];
  assign mag_entrada  = neg_entrada ? (LARGURA'(0) - bus.binario) : bus.binario;

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    carga   = 1'b0;
    passo   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          carga   = 1'b1;
          proximo = CONVERTE;
        end
      end
      CONVERTE: begin
        passo = 1'b1;
        if (contador == ULTIMO) proximo = FIM;
      end
      FIM: begin
        if (bus.inicio) begin
          carga   = 1'b1;
          proximo = CONVERTE;
        end else begin
          proximo = OCIOSO;
        end
      end
      default: proximo = OCIOSO;
    endcase
  end

  // Results are copied out only on the final step, so outputs never show partial work.
  always_ff @(posedge clock) begin
    if (reset) begin
      contador  <= '0;
      magnitude <= '0;
      digitos   <= '0;
      ovf_int   <= 1'b0;
      neg_int   <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      est_q     <= 1'b0;
    end else if (carga) begin
      contador  <= '0;
      magnitude <= mag_entrada;
      digitos   <= '0;
      ovf_int   <= 1'b0;
      neg_int   <= neg_entrada;
    end else if (passo) begin
      contador  <= contador + CW'(1);
      magnitude <= magnitude << 1;
      digitos   <= digitos_prox;
      ovf_int   <= ovf_prox;
      if (contador == ULTIMO) begin
        bcd_q <= digitos_prox;
        est_q <= ovf_prox;
        neg_q <= neg_int;
      end
    end
  end

  assign bus.ocupado  = (estado == CONVERTE);
  assign bus.pronto   = (estado == FIM);
  assign bus.bcd      = bcd_q;
  assign bus.negativo = neg_q;
  assign bus.estouro  = est_q;

endmodule

// File: tb/tb_binario_bcd_seq.sv
// Self-checking bench for binario_bcd_seq: directed cases plus a random
// regression scored against a decimal-string model through a queue.
module tb_binario_bcd_seq;
  import binario_bcd_seq_pkg::*;

  localparam int L  = 32;
  localparam int D  = digitos_min(L);
  localparam int LP = 16;
  localparam int DP = 3;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic           neg;
    logic           ovf;
    int             acc;
  } esperado_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   ciclo = 0;
  int   prontos = 0;
  esperado_t fila[$];

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  binario_bcd_seq_if #(.LARGURA(L),  .DIGITOS(D))  bus ();
  binario_bcd_seq_if #(.LARGURA(LP), .DIGITOS(DP)) bus_p ();

  binario_bcd_seq #(.LARGURA(L), .DIGITOS(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  binario_bcd_seq #(.LARGURA(LP), .DIGITOS(DP)) dut_p (
    .clock (clock),
    .reset (reset),
    .bus   (bus_p)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelo(input logic [63:0] v, input bit sig, input int w, input int d,
                                 output logic [63:0] bcd, output bit neg, output bit ovf);
    logic [63:0]     vm;
    longint unsigned mag;
    string           s;
    vm  = v & ((64'd1 << w) - 64'd1);
    neg = sig && vm[w-1];
    mag = neg ? ((64'd1 << w) - vm) : vm;
    s   = $sformatf("%0d", mag);
    bcd = '0;
    for (int i = 0; i < s.len() && i < d; i++)
      bcd[4*i +: 4] = 4'(s[s.len()-1-i] - "0");
    ovf = (s.len() > d);
  endfunction

  // Every pronto pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    esperado_t e;
    if (!reset && bus.pronto) begin
      if (fila.size() == 0) begin
        check_output("pronto_sem_pedido", 64'(bus.pronto), 64'd0);
      end else begin
        e = fila.pop_front();
        check_output("bcd", 64'(bus.bcd), 64'(e.bcd));
        check_output("negativo", 64'(bus.negativo), 64'(e.neg));
        check_output("estouro", 64'(bus.estouro), 64'(e.ovf));
        check_output("latencia", 64'(ciclo - e.acc + 1), 64'(L + 1));
        check_output("ocupado_fim", 64'(bus.ocupado), 64'd0);
        prontos++;
      end
    end
  end

  task automatic apply_stimulus(input logic [L-1:0] v, input bit sig,
                                input logic [4*D-1:0] eb, input bit en, input bit eo);
    int espera = 0;
    while (bus.ocupado && espera < 200) begin
      @(negedge clock);
      espera++;
    end
    if (espera >= 200) check_output("timeout_ocioso", 64'(bus.ocupado), 64'd0);
    bus.inicio    = 1'b1;
    bus.binario   = v;
    bus.com_sinal = sig;
    fila.push_back('{bcd: eb, neg: en, ovf: eo, acc: ciclo + 1});
    @(negedge clock);
    bus.inicio    = 1'b0;
    bus.binario   = $urandom;
    bus.com_sinal = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fila.size() != 0 || bus.ocupado || bus.pronto) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check_output("timeout_fila", 64'(fila.size()), 64'd0);
  endtask

  task automatic run_pequeno(input logic [LP-1:0] v, input bit sig,
                             input logic [4*DP-1:0] eb, input bit en, input bit eo);
    int n = 0;
    bus_p.inicio    = 1'b1;
    bus_p.binario   = v;
    bus_p.com_sinal = sig;
    @(negedge clock);
    bus_p.inicio    = 1'b0;
    bus_p.binario   = ~v;
    while (!bus_p.pronto && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("p_latencia", 64'(n), 64'(LP));
    check_output("p_bcd", 64'(bus_p.bcd), 64'(eb));
    check_output("p_negativo", 64'(bus_p.negativo), 64'(en));
    check_output("p_estouro", 64'(bus_p.estouro), 64'(eo));
    @(negedge clock);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0]    especiais [6];
    logic [L-1:0]   v;
    logic [63:0]    mb;
    bit             mn, mo, sig;
    int             n, livres, pulsos, t1, t2, a1, antes;

    especiais = '{32'h0, 32'h1, 32'h9, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    reset = 1'b1;
    bus.inicio = 1'b0;   bus.binario = '0;   bus.com_sinal = 1'b0;
    bus_p.inicio = 1'b0; bus_p.binario = '0; bus_p.com_sinal = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rst_ocupado", 64'(bus.ocupado), 64'd0);
    check_output("rst_pronto", 64'(bus.pronto), 64'd0);
    check_output("rst_bcd", 64'(bus.bcd), 64'd0);
    check_output("rst_negativo", 64'(bus.negativo), 64'd0);
    check_output("rst_estouro", 64'(bus.estouro), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    apply_stimulus(32'hFFFFFFFF, 1'b0, 40'h4294967295, 1'b0, 1'b0);
    apply_stimulus(32'h80000000, 1'b1, 40'h2147483648, 1'b1, 1'b0);
    apply_stimulus(32'hFFFFFFFF, 1'b1, 40'h1, 1'b1, 1'b0);
    apply_stimulus(32'h7FFFFFFF, 1'b1, 40'h2147483647, 1'b0, 1'b0);
    apply_stimulus(32'h0, 1'b1, 40'h0, 1'b0, 1'b0);
    wait_idle();

    run_pequeno(16'd1234, 1'b0, 12'h234, 1'b0, 1'b1);
    run_pequeno(16'd999,  1'b0, 12'h999, 1'b0, 1'b0);
    run_pequeno(16'h8000, 1'b1, 12'h768, 1'b1, 1'b1);
    run_pequeno(16'hFC19, 1'b1, 12'h999, 1'b1, 1'b0);
    run_pequeno(16'hFFFF, 1'b0, 12'h535, 1'b0, 1'b1);

    // Back-to-back: inicio held through the first FIM so it reloads there.
    bus.inicio = 1'b1; bus.binario = 32'd0; bus.com_sinal = 1'b0;
    a1 = ciclo + 1;
    fila.push_back('{bcd: 40'h0, neg: 1'b0, ovf: 1'b0, acc: a1});
    @(negedge clock);
    bus.binario = 32'd100;
    fila.push_back('{bcd: 40'h100, neg: 1'b0, ovf: 1'b0, acc: a1 + L + 1});
    n = 0; livres = 0; pulsos = 0; t1 = 0; t2 = 0;
    while (pulsos < 2 && n < 120) begin
      @(negedge clock);
      n++;
      if (bus.pronto) begin
        pulsos++;
        if (pulsos == 1) t1 = ciclo;
        else             t2 = ciclo;
      end else if (!bus.ocupado) begin
        livres++;
      end
      if (pulsos == 1 && !bus.pronto) bus.inicio = 1'b0;
    end
    bus.inicio = 1'b0;
    check_output("b2b_pulsos", 64'(pulsos), 64'd2);
    check_output("b2b_intervalo", 64'(t2 - t1), 64'(L + 1));
    check_output("b2b_ocupado_baixo", 64'(livres), 64'd0);
    wait_idle();

    antes = prontos;
    apply_stimulus(32'd12345678, 1'b0, 40'h0012345678, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    bus.inicio = 1'b1; bus.binario = 32'd999; bus.com_sinal = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;
    wait_idle();
    repeat (40) @(negedge clock);
    check_output("pulso_unico", 64'(prontos - antes), 64'd1);

    // Abort mid-conversion: no pronto may follow and outputs clear.
    antes = prontos;
    bus.inicio = 1'b1; bus.binario = 32'd55555; bus.com_sinal = 1'b0;
    @(negedge clock);
    bus.inicio = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("abort_pronto", 64'(bus.pronto), 64'd0);
    check_output("abort_ocupado", 64'(bus.ocupado), 64'd0);
    check_output("abort_bcd", 64'(bus.bcd), 64'd0);
    check_output("abort_estouro", 64'(bus.estouro), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check_output("abort_sem_pronto", 64'(prontos - antes), 64'd0);
    apply_stimulus(32'd55555, 1'b0, 40'h55555, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      v   = (i % 10 == 0) ? especiais[$urandom_range(0, 5)] : $urandom;
      sig = 1'($urandom_range(0, 1));
      modelo(64'(v), sig, L, D, mb, mn, mo);
      apply_stimulus(v, sig, mb[4*D-1:0], mn, mo);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
